// File: rtl/mod12_ctrl_pkg.sv
// Shared types and constants for the mod-12 counter controller and its display driver.
package mod12_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam int MOD = 12;

  // Segment order {a,b,c,d,e,f,g,dp}, active-high
  localparam logic [7:0] SEG_0    = 8'hFC;
  localparam logic [7:0] SEG_1    = 8'h60;
  localparam logic [7:0] SEG_2    = 8'hDA;
  localparam logic [7:0] SEG_3    = 8'hF2;
  localparam logic [7:0] SEG_4    = 8'h66;
  localparam logic [7:0] SEG_5    = 8'hB6;
  localparam logic [7:0] SEG_6    = 8'hBE;
  localparam logic [7:0] SEG_7    = 8'hE0;
  localparam logic [7:0] SEG_8    = 8'hFE;
  localparam logic [7:0] SEG_9    = 8'hF6;
  localparam logic [7:0] SEG_DASH = 8'h02;

  localparam logic [3:0] CTRL_ONES = 4'b0111;
  localparam logic [3:0] CTRL_TENS = 4'b1011;
  localparam logic [3:0] CTRL_OFF  = 4'b1111;

  function automatic logic [7:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = SEG_0;
      4'd1:    glyph = SEG_1;
      4'd2:    glyph = SEG_2;
      4'd3:    glyph = SEG_3;
      4'd4:    glyph = SEG_4;
      4'd5:    glyph = SEG_5;
      4'd6:    glyph = SEG_6;
      4'd7:    glyph = SEG_7;
      4'd8:    glyph = SEG_8;
      4'd9:    glyph = SEG_9;
      default: glyph = SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/mod12_counter_ctrl_seg7_scan.sv
// Two-digit multiplexed seven-segment driver: free-running slot timer, digit select,
// BCD split of the counter value and glyph lookup, all registered together.
module seg7_scan
  import mod12_ctrl_pkg::*;
#(
  parameter int SCAN_DIV = 2000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] q,
  input  logic       illegal,
  output logic [7:0] segment,
  output logic [3:0] ctrl
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SW-1:0] SCAN_TC = SW'(SCAN_DIV - 1);

  logic [SW-1:0] scan_cnt;
  logic          sel_tens;
  logic [3:0]    ones;
  logic [3:0]    tens;

  always_comb begin
    ones = (q >= 4'd10) ? (q - 4'd10) : q;
    tens = (q >= 4'd10) ? 4'd1 : 4'd0;
  end

  // segment and ctrl are loaded from the same select bit on the same edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt <= '0;
      sel_tens <= 1'b0;
      segment  <= 8'h00;
      ctrl     <= CTRL_OFF;
    end else begin
      if (scan_cnt == SCAN_TC) begin
        scan_cnt <= '0;
        sel_tens <= ~sel_tens;
      end else begin
        scan_cnt <= scan_cnt + SW'(1);
      end
      if (sel_tens) begin
        ctrl    <= CTRL_TENS;
        segment <= illegal ? SEG_DASH : glyph(tens);
      end else begin
        ctrl    <= CTRL_ONES;
        segment <= illegal ? SEG_DASH : glyph(ones);
      end
    end
  end

endmodule

// File: rtl/mod12_counter_ctrl.sv
// Run/pause/clear sequencer for the external mod-12 counter: count-rate prescaler,
// count/clear pulses, illegal-value detection and the display driver.
//
//   state | meaning
//   IDLE  | stopped after reset or clear, prescaler held at 0
//   RUN   | prescaler advancing, cnt_en issued at each terminal count
//   PAUSE | stopped, prescaler frozen so a resume keeps the phase
module mod12_counter_ctrl
  import mod12_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 2000000,
  parameter int SCAN_DIV = 2000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic [3:0] q,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       running,
  output logic       wrap,
  output logic       err,
  output logic [7:0] segment,
  output logic [3:0] ctrl
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_TC = PW'(TICK_DIV - 1);

  state_t        state;
  logic [PW-1:0] presc;
  logic          illegal;

  assign illegal = (q >= 4'(MOD));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      presc   <= '0;
      cnt_en  <= 1'b0;
      cnt_clr <= 1'b0;
      running <= 1'b0;
      wrap    <= 1'b0;
      err     <= 1'b0;
    end else begin
      cnt_en  <= 1'b0;
      cnt_clr <= 1'b0;
      wrap    <= 1'b0;
      err     <= 1'b0;
      if (clear) begin
        state   <= IDLE;
        presc   <= '0;
        cnt_clr <= 1'b1;
        running <= 1'b0;
      end else if (illegal && state != IDLE) begin
        // Recover the datapath but leave sequencing exactly where it was
        err     <= 1'b1;
        cnt_clr <= 1'b1;
        running <= (state == RUN);
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state   <= RUN;
              presc   <= '0;
              running <= 1'b1;
            end else begin
              running <= 1'b0;
            end
          end
          RUN: begin
            if (stop) begin
              state   <= PAUSE;
              running <= 1'b0;
            end else begin
              running <= 1'b1;
              if (presc == PRESC_TC) begin
                presc  <= '0;
                cnt_en <= 1'b1;
                wrap   <= (q == 4'(MOD - 1));
              end else begin
                presc <= presc + PW'(1);
              end
            end
          end
          PAUSE: begin
            if (start) begin
              state   <= RUN;
              running <= 1'b1;
            end else begin
              running <= 1'b0;
            end
          end
          default: begin
            state   <= IDLE;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

  seg7_scan #(
    .SCAN_DIV(SCAN_DIV)
  ) u_scan (
    .clk     (clk),
    .reset   (reset),
    .q       (q),
    .illegal (illegal),
    .segment (segment),
    .ctrl    (ctrl)
  );

endmodule

// File: tb/tb_mod12_counter_ctrl.sv
// Scenario bench for mod12_counter_ctrl with a behavioural mod-12 counter on cnt_en/cnt_clr.
module tb_mod12_counter_ctrl;

  localparam int TICK_DIV = 4;
  localparam int SCAN_DIV = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] q;
  logic [3:0] q_model;
  logic [3:0] force_val = 4'd0;
  logic       force_en = 1'b0;
  logic       cnt_en, cnt_clr, running, wrap, err;
  logic [7:0] segment;
  logic [3:0] ctrl;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] glyph_tb [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                                8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};

  typedef struct {
    int         cyc;
    logic       wrap;
    logic [3:0] q;
  } ev_t;
  ev_t sb[$];

  typedef struct {
    logic [3:0] ctrl;
    logic [7:0] seg;
  } disp_t;
  disp_t dq[$];

  assign q = force_en ? force_val : q_model;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge reset) begin
    if (!reset)       q_model <= 4'd0;
    else if (cnt_clr) q_model <= 4'd0;
    else if (cnt_en)  q_model <= (q_model == 4'd11) ? 4'd0 : q_model + 4'd1;
  end

  mod12_counter_ctrl #(
    .TICK_DIV(TICK_DIV),
    .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .stop    (stop),
    .clear   (clear),
    .q       (q),
    .cnt_en  (cnt_en),
    .cnt_clr (cnt_clr),
    .running (running),
    .wrap    (wrap),
    .err     (err),
    .segment (segment),
    .ctrl    (ctrl)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) tick();
    checks++;
    if (segment !== 8'h00 || ctrl !== 4'b1111) begin
      errors++;
      $display("FAIL reset_display got seg=%h ctrl=%b want seg=00 ctrl=1111", segment, ctrl);
    end
    checks++;
    if ({cnt_en, cnt_clr, running, wrap, err} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_flags got en/clr/run/wrap/err=%b want 00000",
               {cnt_en, cnt_clr, running, wrap, err});
    end
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (cnt_en !== 1'b0 || running !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset got cnt_en=%b running=%b want 0 0", cnt_en, running);
    end
  endtask

  task automatic test_count();
    int s;
    ev_t e;
    s = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (running !== 1'b1) begin
      errors++;
      $display("FAIL start_running got %b want 1", running);
    end
    for (int k = 1; k <= 13; k++) begin
      e.cyc  = s + 1 + TICK_DIV * k;
      e.wrap = (k == 12);
      e.q    = 4'((k - 1) % 12);
      sb.push_back(e);
    end
    for (int i = 0; i < 80 && sb.size() > 0; i++) begin
      if (cnt_en === 1'b1) begin
        e = sb.pop_front();
        checks++;
        if (cyc != e.cyc || wrap !== e.wrap || q !== e.q) begin
          errors++;
          $display("FAIL count_step got cyc=%0d wrap=%b q=%0d want cyc=%0d wrap=%b q=%0d",
                   cyc, wrap, q, e.cyc, e.wrap, e.q);
        end
      end else if (wrap !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL wrap_alone got wrap=%b want 0 without cnt_en", wrap);
      end
      if (sb.size() > 0) tick();
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL count_timeout got %0d pending steps want 0", sb.size());
    end
    sb.delete();
  endtask

  // Entered on the cycle the last cnt_en is visible, so the prescaler phase is known
  task automatic test_pause_resume();
    int s;
    int seen;
    ev_t e;
    repeat (2) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (running !== 1'b0) begin
      errors++;
      $display("FAIL stop_running got %b want 0", running);
    end
    seen = 0;
    repeat (10) begin
      tick();
      if (cnt_en !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL paused_cnt_en got %0d pulses want 0", seen);
    end
    s = cyc;
    e.cyc  = s + 3;
    e.wrap = 1'b0;
    e.q    = q_model;
    sb.push_back(e);
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (running !== 1'b1) begin
      errors++;
      $display("FAIL resume_running got %b want 1", running);
    end
    for (int i = 0; i < 10 && sb.size() > 0; i++) begin
      if (cnt_en === 1'b1) begin
        e = sb.pop_front();
        checks++;
        if (cyc != e.cyc || q !== e.q) begin
          errors++;
          $display("FAIL resume_step got cyc=%0d q=%0d want cyc=%0d q=%0d", cyc, q, e.cyc, e.q);
        end
      end
      if (sb.size() > 0) tick();
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL resume_timeout got %0d pending want 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_same_cycle();
    int clr_cnt;
    stop = 1'b1;
    start = 1'b1;
    tick();
    stop = 1'b0;
    start = 1'b0;
    checks++;
    if (running !== 1'b0) begin
      errors++;
      $display("FAIL stop_start got running=%b want 0", running);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    clear = 1'b1;
    stop = 1'b1;
    start = 1'b1;
    tick();
    clear = 1'b0;
    stop = 1'b0;
    start = 1'b0;
    clr_cnt = (cnt_clr === 1'b1) ? 1 : 0;
    checks++;
    if (running !== 1'b0) begin
      errors++;
      $display("FAIL clear_all_running got %b want 0", running);
    end
    repeat (6) begin
      tick();
      if (cnt_clr === 1'b1) clr_cnt++;
    end
    checks++;
    if (clr_cnt != 1 || q !== 4'd0) begin
      errors++;
      $display("FAIL clear_all got clr_pulses=%0d q=%0d want 1 0", clr_cnt, q);
    end
    checks++;
    if (running !== 1'b0 || cnt_en !== 1'b0) begin
      errors++;
      $display("FAIL clear_idle got running=%b cnt_en=%b want 0 0", running, cnt_en);
    end
  endtask

  task automatic run_disp(input logic [3:0] v);
    logic [3:0] prev;
    logic [7:0] g_ones, g_tens;
    logic       tens_first;
    int         i;
    disp_t      d;
    g_ones = glyph_tb[v % 10];
    g_tens = glyph_tb[(v >= 4'd10) ? 1 : 0];
    force_val = v;
    force_en = 1'b1;
    repeat (2) tick();
    prev = ctrl;
    i = 0;
    while (ctrl === prev && i < 10) begin
      tick();
      i++;
    end
    checks++;
    if (ctrl === prev || (ctrl !== 4'b0111 && ctrl !== 4'b1011)) begin
      errors++;
      $display("FAIL scan_toggle q=%0d got ctrl=%b want a toggle to 0111/1011", v, ctrl);
    end
    tens_first = (ctrl === 4'b1011);
    for (int j = 0; j < 12; j++) begin
      if (((j / SCAN_DIV) % 2 == 1) ^ tens_first) begin
        d.ctrl = 4'b1011;
        d.seg  = g_tens;
      end else begin
        d.ctrl = 4'b0111;
        d.seg  = g_ones;
      end
      dq.push_back(d);
    end
    while (dq.size() > 0) begin
      d = dq.pop_front();
      checks++;
      if (ctrl !== d.ctrl || segment !== d.seg) begin
        errors++;
        $display("FAIL scan q=%0d got ctrl=%b seg=%h want ctrl=%b seg=%h",
                 v, ctrl, segment, d.ctrl, d.seg);
      end
      tick();
    end
    force_en = 1'b0;
  endtask

  task automatic test_display();
    run_disp(4'd11);
    run_disp(4'd7);
  endtask

  task automatic test_illegal();
    logic seen_ones, seen_tens, got_en;
    int bad;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    force_val = 4'd13;
    force_en = 1'b1;
    tick();
    checks++;
    if (err !== 1'b1 || cnt_clr !== 1'b1 || running !== 1'b1) begin
      errors++;
      $display("FAIL illegal_flag got err=%b clr=%b run=%b want 1 1 1", err, cnt_clr, running);
    end
    seen_ones = 1'b0;
    seen_tens = 1'b0;
    bad = 0;
    repeat (7) begin
      tick();
      if (err !== 1'b1 || segment !== 8'h02) bad++;
      if (ctrl === 4'b0111) seen_ones = 1'b1;
      if (ctrl === 4'b1011) seen_tens = 1'b1;
    end
    checks++;
    if (bad != 0 || !seen_ones || !seen_tens) begin
      errors++;
      $display("FAIL illegal_dash got bad=%0d ones=%b tens=%b want 0 1 1", bad, seen_ones, seen_tens);
    end
    force_en = 1'b0;
    tick();
    checks++;
    if (err !== 1'b0 || q !== 4'd0) begin
      errors++;
      $display("FAIL illegal_release got err=%b q=%0d want 0 0", err, q);
    end
    got_en = 1'b0;
    for (int i = 0; i < 4 * TICK_DIV && !got_en; i++) begin
      tick();
      if (cnt_en === 1'b1) got_en = 1'b1;
    end
    tick();
    checks++;
    if (!got_en || q !== 4'd1) begin
      errors++;
      $display("FAIL illegal_resume got cnt_en_seen=%b q=%0d want 1 1", got_en, q);
    end
  endtask

  task automatic test_reset_mid();
    int i;
    int s;
    int seen;
    i = 0;
    while (q_model !== 4'd5 && i < 200) begin
      tick();
      i++;
    end
    checks++;
    if (q_model !== 4'd5 || running !== 1'b1) begin
      errors++;
      $display("FAIL reach_q5 got q=%0d running=%b want 5 1", q_model, running);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (segment !== 8'h00 || ctrl !== 4'b1111 || running !== 1'b0 ||
        cnt_en !== 1'b0 || cnt_clr !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got seg=%h ctrl=%b run=%b en=%b clr=%b want 00 1111 0 0 0",
               segment, ctrl, running, cnt_en, cnt_clr);
    end
    repeat (2) tick();
    reset = 1'b1;
    seen = 0;
    repeat (12) begin
      tick();
      if (cnt_en !== 1'b0 || running !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL post_reset_idle got %0d active cycles want 0", seen);
    end
    s = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    i = 0;
    while (cnt_en !== 1'b1 && i < 20) begin
      tick();
      i++;
    end
    checks++;
    if (cnt_en !== 1'b1 || cyc != s + 1 + TICK_DIV) begin
      errors++;
      $display("FAIL post_reset_start got cyc=%0d en=%b want cyc=%0d en=1", cyc, cnt_en, s + 1 + TICK_DIV);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_count();
    test_pause_resume();
    test_same_cycle();
    test_display();
    test_illegal();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
